multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 2-bit-opcode CPU datapath: 00 add (R-type), 01 load, 10 store, 11 branch.
- Steps each instruction through fetch/decode/execute/memory/writeback and drives the datapath control lines per state.
- Handshakes with instruction and data memories that have variable latency, with a wait timeout.
- Sits between the instruction register/PC logic and the register file, ALU and data memory.

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles waiting for imem_ready/dmem_ready before faulting (must be >= 1)
TO_W, 5, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  in IDLE, begin fetching
stop  in  1  request halt after the current instruction
op  in  2  opcode field of the instruction register, valid from DECODE onward
zero  in  1  ALU zero flag, used for branch
imem_ready  in  1  instruction memory has data this cycle
dmem_ready  in  1  data memory access completes this cycle
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  1  0 = PC+1, 1 = branch target
alu_src  out  1  1 = immediate operand
reg_dst  out  1  1 = rd destination (R-type)
mem_read  out  1  data memory read
mem_write  out  1  data memory write
mem_to_reg  out  1  1 = writeback from memory
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
busy  out  1  state is not IDLE or FAULT
fault  out  1  memory wait timeout occurred (sticky)
state  out  3  current state encoding
instr_count  out  16  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (synchronous, high):
  - state=IDLE, op_q=00, wait_cnt=0, stop_pending=0, fault=0.
  - All outputs 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. Value 7 is unreachable; it decodes to IDLE on the next edge.
- Outputs are decoded combinationally from state, op_q and the ready inputs. Any output not listed for a state is 0.
- IDLE:
  - If start=1, go to FETCH. stop is ignored in IDLE.
- FETCH:
  - imem_req=1.
  - If imem_ready=1: ir_write=1, pc_write=1, pc_src=0 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Single cycle. op_q <= op; go to EXEC.
- EXEC (single cycle):
  - alu_src = (op_q != 00); reg_dst = (op_q == 00).
  - Branch (11): pc_write = zero, pc_src=1, instr_done=1, then end-of-instruction.
  - Add (00): go to WB.
  - Load/store (01/10): go to MEM.
- MEM:
  - alu_src=1.
  - Load: mem_read=1, held until dmem_ready; then go to WB.
  - Store: mem_write=1, held until dmem_ready; in the dmem_ready cycle instr_done=1, then end-of-instruction.
- WB (single cycle):
  - reg_write=1, instr_done=1.
  - mem_to_reg = (op_q == 01); reg_dst = (op_q == 00).
  - Then end-of-instruction.
- End-of-instruction: next state is IDLE if stop_pending, or stop is 1 in this cycle; otherwise FETCH. stop_pending clears when IDLE is entered.
- stop_pending: set when stop=1 in any busy state; cleared on entering IDLE.
- Wait timeout:
  - wait_cnt clears on entry to FETCH/MEM and increments each cycle the relevant ready is 0.
  - If wait_cnt reaches MEM_TIMEOUT-1 and ready is still 0, go to FAULT: fault=1, all control outputs 0.
  - FAULT is left only by reset.
  - A ready arriving in the final allowed cycle completes normally.
- Latency with zero wait: add 4 cycles, load 5, store 4, branch 3. Each memory wait cycle adds 1.
- Reset mid-instruction: abandons the instruction the same edge; no further write strobes.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: instr_count increments on every instr_done pulse and wraps 0xFFFF to 0x0000. It resets to 0 and holds its value in IDLE and FAULT.
- Undefined: instr_count is tied to 0 and no counter logic is built. The port stays present so instantiations are identical either way.

Test Plan:
- Reset, start=1 for one cycle, ready inputs always 1, op=00 -> states 1,2,3,5,1; reg_write=1 and reg_dst=1 only in the WB cycle; instr_done pulses once; instr_count=1 with PERF_CNT_EN.
- op=01, dmem_ready low for 3 MEM cycles -> mem_read high for 4 cycles, then WB with mem_to_reg=1 and reg_write=1; total 8 cycles.
- op=11 with zero=1, then again with zero=0 -> EXEC shows pc_write=1/pc_src=1 in the first case and pc_write=0/pc_src=1 in the second; neither reaches MEM or WB.
- op=10, stop pulsed during MEM -> mem_write until dmem_ready, instr_done pulse, state goes to IDLE, busy=0, no further imem_req.
- imem_ready held 0, MEM_TIMEOUT=16 -> FAULT entered after 16 FETCH cycles, fault=1, all strobes 0, start ignored; reset returns to IDLE with fault=0.
- Reset asserted in WB -> reg_write=0 on the next cycle, state=0, instr_count=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the 2-bit-opcode CPU (add/load/store/branch).
// Define PERF_CNT_EN to build the retired-instruction counter on o_instr_count.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [1:0]  i_op,
  input  logic        i_zero,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  output logic        o_imem_req,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_pc_src,
  output logic        o_alu_src,
  output logic        o_reg_dst,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_instr_done,
  output logic        o_busy,
  output logic        o_fault,
  output logic [2:0]  o_state,
  output logic [15:0] o_instr_count
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BR    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  state_t            w_eoi_state;
  logic [1:0]        r_op;
  logic [TO_W-1:0]   r_wait_cnt;
  logic              r_stop_pending;
  logic              w_ready;
  logic              w_timeout;
  logic              w_busy;
  logic              w_waiting;

  assign w_ready     = (r_state == S_FETCH) ? i_imem_ready : i_dmem_ready;
  assign w_waiting   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout   = (r_wait_cnt == TO_W'(MEM_TIMEOUT - 1)) && !w_ready;
  assign w_busy      = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign w_eoi_state = (r_stop_pending || i_stop) ? S_IDLE : S_FETCH;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:   w_next_state = i_start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (i_imem_ready)   w_next_state = S_DECODE;
        else if (w_timeout) w_next_state = S_FAULT;
        else                w_next_state = S_FETCH;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        case (r_op)
          OP_BR:   w_next_state = w_eoi_state;
          OP_ADD:  w_next_state = S_WB;
          default: w_next_state = S_MEM;
        endcase
      end
      S_MEM: begin
        if (i_dmem_ready)   w_next_state = (r_op == OP_LOAD) ? S_WB : w_eoi_state;
        else if (w_timeout) w_next_state = S_FAULT;
        else                w_next_state = S_MEM;
      end
      S_WB:     w_next_state = w_eoi_state;
      S_FAULT:  w_next_state = S_FAULT;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Latched opcode, memory wait counter and deferred stop request
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op           <= 2'b00;
      r_wait_cnt     <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_op <= i_op;

      if ((w_next_state != r_state) &&
          ((w_next_state == S_FETCH) || (w_next_state == S_MEM)))
        r_wait_cnt <= '0;
      else if (w_waiting && !w_ready)
        r_wait_cnt <= r_wait_cnt + TO_W'(1);

      if (w_next_state == S_IDLE)  r_stop_pending <= 1'b0;
      else if (w_busy && i_stop)   r_stop_pending <= 1'b1;
    end
  end

  // Control outputs decoded from state, latched opcode and ready inputs
  always_comb begin
    o_imem_req   = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    o_alu_src    = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_instr_done = 1'b0;
    o_busy       = w_busy;
    o_fault      = (r_state == S_FAULT);
    o_state      = r_state;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        o_alu_src = (r_op != OP_ADD);
        o_reg_dst = (r_op == OP_ADD);
        if (r_op == OP_BR) begin
          o_pc_write   = i_zero;
          o_pc_src     = 1'b1;
          o_instr_done = 1'b1;
        end
      end
      S_MEM: begin
        o_alu_src   = 1'b1;
        o_mem_read  = (r_op == OP_LOAD);
        o_mem_write = (r_op == OP_STORE);
        o_instr_done = (r_op == OP_STORE) && i_dmem_ready;
      end
      S_WB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        o_mem_to_reg = (r_op == OP_LOAD);
        o_reg_dst    = (r_op == OP_ADD);
      end
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic [15:0] r_instr_count;

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge i_clk) begin
    if (i_reset)           r_instr_count <= 16'd0;
    else if (o_instr_done) r_instr_count <= r_instr_count + 16'd1;
  end

  assign o_instr_count = r_instr_count;
`else
  assign o_instr_count = 16'd0;
`endif

endmodule
